// File: rtl/regwb_sched.sv
// Writeback-port scheduler: round-robin arbitration of NREQ writeback sources onto the
// single register-file write port, plus a busy-register scoreboard that stalls issue on RAW/WAW.
module regwb_sched #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 iss_valid,
  input  logic [4:0]           iss_rd,
  input  logic [4:0]           iss_rs1,
  input  logic [4:0]           iss_rs2,
  output logic                 iss_stall,
  input  logic [NREQ-1:0]      wb_valid,
  input  logic [5*NREQ-1:0]    wb_addr,
  input  logic [XLEN*NREQ-1:0] wb_data,
  output logic [NREQ-1:0]      wb_ready,
  output logic                 rf_wen,
  output logic [4:0]           rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 sb_empty
);

  localparam int PW = $clog2(NREQ);

  logic [31:1]     busy_q, busy_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            rf_wen_q, rf_wen_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic [NREQ-1:0] vld_win;
  logic            gnt_found;
  logic [PW-1:0]   gnt_idx;
  logic [PW:0]     gnt_sum;
  logic [4:0]      sel_addr;
  logic [XLEN-1:0] sel_data;

  logic [31:1]     clr_vec, set_vec, haz_vec;
  logic [31:0]     haz_lookup;
  logic            stall_int;
  logic            issue_fire;

  // Rotate valids so bit k is requester (rr_ptr + k) mod NREQ; the first set bit wins.
  // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    vld_win   = NREQ'({wb_valid, wb_valid} >> rr_ptr_q);
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && vld_win[k]) begin
        gnt_found = 1'b1;
        gnt_sum   = {1'b0, rr_ptr_q} + (PW+1)'(k);
        gnt_idx   = (gnt_sum >= (PW+1)'(NREQ)) ? PW'(gnt_sum - (PW+1)'(NREQ)) : PW'(gnt_sum);
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == PW'(k)) begin
        sel_addr = wb_addr[5*k +: 5];
        sel_data = wb_data[XLEN*k +: XLEN];
      end
    end
  end

  always_comb begin
    wb_ready = '0;
    if (reset_n && gnt_found) wb_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (gnt_found) begin
      rr_ptr_d   = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      rf_wen_d   = (sel_addr != 5'd0);
      rf_waddr_d = sel_addr;
      rf_wdata_d = sel_data;
    end
  end

  // A register being written this cycle is bypassed by the register file, so it is not a hazard.
  always_comb begin
    clr_vec = '0;
    for (int r = 1; r < 32; r++) clr_vec[r] = rf_wen_q && (rf_waddr_q == 5'(r));
    haz_vec    = busy_q & ~clr_vec;
    haz_lookup = {haz_vec, 1'b0};
    stall_int  = iss_valid && (haz_lookup[iss_rs1] || haz_lookup[iss_rs2] || haz_lookup[iss_rd]);
    issue_fire = iss_valid && !stall_int && (iss_rd != 5'd0);
    set_vec    = '0;
    for (int r = 1; r < 32; r++) set_vec[r] = issue_fire && (iss_rd == 5'(r));
    busy_d     = (busy_q & ~clr_vec) | set_vec;
  end

  assign iss_stall = reset_n & stall_int;
  assign sb_empty  = (busy_q == '0);
  assign rf_wen    = rf_wen_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q     <= '0;
      rr_ptr_q   <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      busy_q     <= busy_d;
      rr_ptr_q   <= rr_ptr_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

endmodule

// File: tb/tb_regwb_sched.sv
// Scoreboard bench for regwb_sched: directed stimulus pushes expected grants and writes,
// a monitor pops and compares them whenever the DUT shows a grant or a register-file write.
module tb_regwb_sched;
  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic            clk;
  logic            reset_n;
  logic            iss_valid;
  logic [4:0]      iss_rd, iss_rs1, iss_rs2;
  logic            iss_stall;
  logic [2:0]      wb_valid;
  logic [14:0]     wb_addr;
  logic [95:0]     wb_data;
  logic [2:0]      wb_ready;
  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [31:0]     rf_wdata;
  logic            sb_empty;

  regwb_sched #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_stall(iss_stall),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .sb_empty(sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  int  checks = 0;
  int  errors = 0;
  int  exp_gnt[$];
  wr_t exp_wr[$];

  localparam logic [31:0] D0 = 32'hA000_0000;
  localparam logic [31:0] D1 = 32'hA111_1111;
  localparam logic [31:0] D2 = 32'hA222_2222;
  localparam logic [31:0] DX = 32'hDEAD_0003;
  localparam logic [31:0] D8 = 32'hBEEF_0008;
  localparam logic [31:0] D4 = 32'hC0DE_0004;
  localparam logic [31:0] DZ = 32'h1234_5678;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic set_wb(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2);
    wb_valid = v;
    wb_addr  = {a2, a1, a0};
    wb_data  = {d2, d1, d0};
  endtask

  task automatic iss(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2);
    iss_valid = v;
    iss_rd    = rd;
    iss_rs1   = rs1;
    iss_rs2   = rs2;
  endtask

  // Monitor: compares every visible grant and every register-file write against the queues.
  initial begin
    int  g;
    wr_t w;
    forever begin
      @(negedge clk);
      if (wb_ready !== 3'b000) begin
        if (exp_gnt.size() == 0) check("gnt_unexpected", 64'(wb_ready), 64'd0);
        else begin
          g = exp_gnt.pop_front();
          check("gnt", 64'(wb_ready), 64'(3'b001 << g));
        end
      end
      if (rf_wen === 1'b1) begin
        if (exp_wr.size() == 0) check("wr_unexpected", 64'(rf_wen), 64'd0);
        else begin
          w = exp_wr.pop_front();
          check("wr_addr", 64'(rf_waddr), 64'(w.addr));
          check("wr_data", 64'(rf_wdata), 64'(w.data));
        end
      end
    end
  end

  int          rr_g[6] = '{0, 1, 2, 0, 1, 2};
  logic [4:0]  rr_a[6] = '{5'd5, 5'd6, 5'd7, 5'd5, 5'd6, 5'd7};
  logic [31:0] rr_d[6] = '{D0, D1, D2, D0, D1, D2};

  initial begin
    // Reset held with every input active.
    reset_n = 1'b0;
    iss(1'b1, 5'd3, 5'd3, 5'd3);
    set_wb(3'b111, 5'd5, 5'd6, 5'd7, D0, D1, D2);
    repeat (2) to_sample();
    check("rst_ready", 64'(wb_ready), 64'd0);
    check("rst_stall", 64'(iss_stall), 64'd0);
    check("rst_wen", 64'(rf_wen), 64'd0);
    check("rst_sb_empty", 64'(sb_empty), 64'd1);

    // Round-robin with all three requesters valid for six cycles.
    for (int i = 0; i < 6; i++) begin
      exp_gnt.push_back(rr_g[i]);
      exp_wr.push_back('{rr_a[i], rr_d[i]});
    end
    iss(1'b0, 5'd0, 5'd0, 5'd0);
    to_drive();
    reset_n = 1'b1;
    repeat (6) to_drive();
    set_wb(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    to_sample();
    to_drive();
    to_sample();
    check("hold_wen", 64'(rf_wen), 64'd0);
    check("hold_addr", 64'(rf_waddr), 64'd7);
    check("hold_data", 64'(rf_wdata), 64'(D2));

    // RAW stall released by the bypass cycle.
    to_drive(); iss(1'b1, 5'd3, 5'd0, 5'd0);
    to_sample(); check("raw_issue", 64'(iss_stall), 64'd0);
    to_drive(); iss(1'b1, 5'd8, 5'd3, 5'd0);
    to_sample(); check("raw_stall1", 64'(iss_stall), 64'd1);
    check("raw_sb_busy", 64'(sb_empty), 64'd0);
    to_drive();
    to_sample(); check("raw_stall2", 64'(iss_stall), 64'd1);
    to_drive(); set_wb(3'b001, 5'd3, 5'd0, 5'd0, DX, 32'd0, 32'd0);
    exp_gnt.push_back(0); exp_wr.push_back('{5'd3, DX});
    to_sample(); check("raw_stall_hs", 64'(iss_stall), 64'd1);
    to_drive(); set_wb(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    to_sample(); check("raw_bypass", 64'(iss_stall), 64'd0);
    to_drive(); iss(1'b1, 5'd0, 5'd3, 5'd0);
    to_sample(); check("raw_cleared", 64'(iss_stall), 64'd0);
    check("raw_sb_busy8", 64'(sb_empty), 64'd0);
    to_drive(); iss(1'b0, 5'd0, 5'd0, 5'd0);
    set_wb(3'b010, 5'd0, 5'd8, 5'd0, 32'd0, D8, 32'd0);
    exp_gnt.push_back(1); exp_wr.push_back('{5'd8, D8});
    to_drive(); set_wb(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    to_drive();
    to_sample(); check("raw_sb_empty", 64'(sb_empty), 64'd1);

    // Same register cleared and re-issued in one cycle: set wins.
    to_drive(); iss(1'b1, 5'd4, 5'd0, 5'd0);
    to_sample(); check("sim_issue", 64'(iss_stall), 64'd0);
    to_drive(); iss(1'b0, 5'd0, 5'd0, 5'd0);
    set_wb(3'b100, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0, D4);
    exp_gnt.push_back(2); exp_wr.push_back('{5'd4, D4});
    to_drive(); set_wb(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    iss(1'b1, 5'd4, 5'd0, 5'd0);
    to_sample(); check("sim_nostall", 64'(iss_stall), 64'd0);
    to_drive(); iss(1'b1, 5'd0, 5'd4, 5'd0);
    to_sample(); check("sim_still_busy", 64'(iss_stall), 64'd1);
    check("sim_sb", 64'(sb_empty), 64'd0);
    to_drive(); iss(1'b0, 5'd0, 5'd0, 5'd0);
    set_wb(3'b001, 5'd4, 5'd0, 5'd0, D1, 32'd0, 32'd0);
    exp_gnt.push_back(0); exp_wr.push_back('{5'd4, D1});
    to_drive(); set_wb(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    to_drive();
    to_sample(); check("sim_cleared", 64'(sb_empty), 64'd1);

    // x0 destination on issue and on writeback.
    to_drive(); iss(1'b1, 5'd0, 5'd0, 5'd0);
    to_sample(); check("x0_nostall", 64'(iss_stall), 64'd0);
    to_drive(); iss(1'b0, 5'd0, 5'd0, 5'd0);
    to_sample(); check("x0_sb_empty", 64'(sb_empty), 64'd1);
    to_drive(); set_wb(3'b010, 5'd0, 5'd0, 5'd0, 32'd0, DZ, 32'd0);
    exp_gnt.push_back(1);
    to_drive(); set_wb(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    to_sample(); check("x0_no_wen", 64'(rf_wen), 64'd0);
    check("x0_waddr", 64'(rf_waddr), 64'd0);
    check("x0_wdata", 64'(rf_wdata), 64'(DZ));

    // Reset asserted while x5 is busy and requester 1 is granted.
    to_drive(); iss(1'b1, 5'd5, 5'd0, 5'd0);
    to_sample(); check("mr_issue", 64'(iss_stall), 64'd0);
    to_drive(); iss(1'b0, 5'd0, 5'd0, 5'd0);
    set_wb(3'b010, 5'd0, 5'd6, 5'd0, 32'd0, D8, 32'd0);
    exp_gnt.push_back(1);
    to_sample();
    #1 reset_n = 1'b0;
    iss(1'b1, 5'd0, 5'd5, 5'd0);
    #1;
    check("mr_sb_empty", 64'(sb_empty), 64'd1);
    check("mr_ready", 64'(wb_ready), 64'd0);
    check("mr_stall", 64'(iss_stall), 64'd0);
    to_drive();
    check("mr_wen", 64'(rf_wen), 64'd0);
    iss(1'b0, 5'd0, 5'd0, 5'd0);
    set_wb(3'b111, 5'd9, 5'd10, 5'd11, D0, D1, D2);
    exp_gnt.push_back(0); exp_wr.push_back('{5'd9, D0});
    reset_n = 1'b1;
    to_drive(); set_wb(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    to_sample();
    to_drive();
    to_sample();

    check("gnt_queue_drained", 64'(exp_gnt.size()), 64'd0);
    check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
